// File: rtl/ped_request_conditioner.sv
// Pedestrian request conditioner.
// Turns the raw, bouncy, asynchronous push-button into a clean, latched
// request level for the pedestrian signal controller. The button is
// synchronised and debounced, a request is held until the controller enters
// its walk state, and a tick-timed lockout follows every serviced cycle so
// back-to-back presses cannot starve the main road.

module ped_request_conditioner #(
   parameter int unsigned DB_CYCLES     = 4,  // 1..15 stable samples before btn_db follows
   parameter int unsigned LOCKOUT_TICKS = 3   // 0..15 tick pulses spent in LOCKOUT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_raw,
   input  logic       tick,
   input  logic [1:0] ctrl_state,
   output logic       ped_sensor,
   output logic       lockout_active,
   output logic       btn_db,
   output logic [7:0] press_count,
   output logic [1:0] req_state
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      PENDING  = 2'b01,
      SERVICED = 2'b10,
      LOCKOUT  = 2'b11
   } req_state_t;

   // Terminal values of the two 4-bit counters. LOCK_LAST is unused when
   // LOCKOUT_TICKS is 0 (LOCK_NONE short-circuits the lockout).
   localparam logic [3:0] DB_LAST   = 4'(DB_CYCLES - 1);
   localparam logic [3:0] LOCK_LAST = 4'(LOCKOUT_TICKS - 1);
   localparam bit         LOCK_NONE = (LOCKOUT_TICKS == 0);

   // Controller walk state, and idle/red (11 is folded onto 00).
   localparam logic [1:0] CTRL_WALK = 2'b01;

   logic       r_sync1;
   logic       r_sync2;
   logic       r_btn_db;
   logic       r_btn_db_prev;
   logic [3:0] r_db_cnt;
   logic [7:0] r_press_count;

   req_state_t r_state;
   logic [3:0] r_lock_cnt;
   logic       r_early_req;
   logic       r_ped_sensor;
   logic       r_lockout_active;

   req_state_t w_state_nxt;
   logic [3:0] w_lock_cnt_nxt;
   logic       w_early_nxt;
   logic       w_lock_exit;
   logic       w_press;
   logic       w_ctrl_walk;
   logic       w_ctrl_idle;

   assign w_press     = r_btn_db & ~r_btn_db_prev;
   assign w_ctrl_walk = (ctrl_state == CTRL_WALK);
   assign w_ctrl_idle = (ctrl_state[1] == ctrl_state[0]);

   // Two-flop synchroniser for the asynchronous button input.
   // NOTE: every flop here uses an asynchronous reset in the sensitivity list,
   // so reset clears state immediately, without waiting for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the old sync1,
         // giving a real two-stage chain rather than a single flop.
         r_sync1 <= btn_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Debounce: btn_db follows sync2 only after DB_CYCLES consecutive
   // disagreeing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn_db <= 1'b0;
         r_db_cnt <= 4'd0;
      end else if (r_sync2 != r_btn_db) begin
         if (r_db_cnt == DB_LAST) begin
            r_btn_db <= r_sync2;
            r_db_cnt <= 4'd0;
         end else begin
            r_db_cnt <= r_db_cnt + 4'd1;
         end
      end else begin
         r_db_cnt <= 4'd0;
      end
   end

   // Rising-edge detect history and saturating press counter (any state).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_btn_db_prev <= 1'b0;
         r_press_count <= 8'd0;
      end else begin
         r_btn_db_prev <= r_btn_db;
         if (w_press && (r_press_count != 8'hFF)) begin
            r_press_count <= r_press_count + 8'd1;
         end
      end
   end

   // Request FSM state, lockout bookkeeping and registered Moore outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state          <= IDLE;
         r_lock_cnt       <= 4'd0;
         r_early_req      <= 1'b0;
         r_ped_sensor     <= 1'b0;
         r_lockout_active <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_lock_cnt       <= w_lock_cnt_nxt;
         r_early_req      <= w_early_nxt;
         r_ped_sensor     <= (w_state_nxt == PENDING);
         r_lockout_active <= (w_state_nxt == LOCKOUT);
      end
   end

   // Next-state logic: request latching, service detection and lockout timing.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would infer a latch.
      w_state_nxt    = r_state;
      w_lock_cnt_nxt = r_lock_cnt;
      w_early_nxt    = r_early_req;
      w_lock_exit    = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_press) begin
               w_state_nxt = PENDING;
            end
         end

         PENDING: begin
            // Extra presses only bump press_count.
            if (w_ctrl_walk) begin
               w_state_nxt = SERVICED;
            end
         end

         SERVICED: begin
            // Clearance (10) keeps waiting; presses here are discarded.
            if (w_ctrl_idle) begin
               w_state_nxt    = LOCKOUT;
               w_lock_cnt_nxt = 4'd0;
               w_early_nxt    = 1'b0;
            end
         end

         LOCKOUT: begin
            if (LOCK_NONE) begin
               w_lock_exit = 1'b1;
            end else if (tick) begin
               if (r_lock_cnt == LOCK_LAST) begin
                  w_lock_exit = 1'b1;
               end else begin
                  w_lock_cnt_nxt = r_lock_cnt + 4'd1;
               end
            end

            // A press on the exit edge is served just like a remembered one.
            if (w_lock_exit) begin
               w_state_nxt = (r_early_req || w_press) ? PENDING : IDLE;
               w_early_nxt = 1'b0;
            end else if (w_press) begin
               w_early_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign ped_sensor     = r_ped_sensor;
   assign lockout_active = r_lockout_active;
   assign btn_db         = r_btn_db;
   assign press_count    = r_press_count;
   assign req_state      = r_state;

endmodule
